// File: rtl/mem_dbus_ctrl_if.sv
// Data-bus handshake between the MEM-stage controller (master) and the memory system (slave).
interface mem_dbus_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, we, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, we, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues loads/stores, freezes the pipe while busy, extends load data.
// Optional request timeout with DBE reporting is enabled by defining DBUS_TIMEOUT_EN.
module mem_dbus_ctrl (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            pipe_adv,
    input  logic [7:0]      mem_memtype,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_din,
    input  logic [4:0]      mem_exccode_in,
    mem_dbus_ctrl_if.master dbus,
    output logic            stallreq_mem,
    output logic [31:0]     load_data,
    output logic            load_valid,
    output logic [4:0]      mem_exccode_out
);
    localparam logic [4:0] EXC_NONE = 5'h1F;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_DBE  = 5'h07;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;
    state_t state, next_state;

    logic        is_load;
    logic        misaligned;
    logic        access_valid;
    logic [4:0]  load_type_q;
    logic [1:0]  lane_q;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic        capture;
    logic        time_up;
    logic        timed_out;

    assign is_load      = |mem_memtype[4:0];
    assign misaligned   = ((mem_memtype[2] | mem_memtype[3] | mem_memtype[6]) & mem_addr[0])
                        | ((mem_memtype[4] | mem_memtype[7]) & (mem_addr[1:0] != 2'b00));
    assign access_valid = (|mem_memtype) && (mem_exccode_in == EXC_NONE) && !misaligned && !flush;

    // Store data is replicated across lanes so the strobes alone pick the written bytes
    always_comb begin
        wstrb_c = 4'b0000;
        wdata_c = mem_din;
        if (mem_memtype[5]) begin
            wstrb_c = 4'b0001 << mem_addr[1:0];
            wdata_c = {4{mem_din[7:0]}};
        end else if (mem_memtype[6]) begin
            wstrb_c = 4'b0011 << mem_addr[1:0];
            wdata_c = {2{mem_din[15:0]}};
        end else if (mem_memtype[7]) begin
            wstrb_c = 4'b1111;
        end
    end

    always_comb begin
        case (lane_q)
            2'd0:    lane_byte = dbus.rdata[7:0];
            2'd1:    lane_byte = dbus.rdata[15:8];
            2'd2:    lane_byte = dbus.rdata[23:16];
            default: lane_byte = dbus.rdata[31:24];
        endcase
        lane_half = lane_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
        load_ext  = dbus.rdata;
        if (load_type_q[0])      load_ext = {{24{lane_byte[7]}}, lane_byte};
        else if (load_type_q[1]) load_ext = {24'h000000, lane_byte};
        else if (load_type_q[2]) load_ext = {{16{lane_half[15]}}, lane_half};
        else if (load_type_q[3]) load_ext = {16'h0000, lane_half};
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (access_valid) next_state = REQ;
            REQ: begin
                if (dbus.addr_ok && dbus.data_ok) next_state = DONE;
                else if (dbus.addr_ok)            next_state = WAIT;
                else if (flush)                   next_state = IDLE;
                else if (time_up)                 next_state = DONE;
            end
            // A flushed instruction whose data arrives in the same cycle has nothing left to drain
            WAIT: begin
                if (dbus.data_ok) next_state = flush ? IDLE : DONE;
                else if (flush)   next_state = DRAIN;
            end
            DONE:  if (pipe_adv || flush) next_state = IDLE;
            DRAIN: if (dbus.data_ok) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dbus.req     = 1'b0;
        stallreq_mem = 1'b0;
        case (state)
            IDLE:  stallreq_mem = access_valid;
            REQ: begin
                dbus.req     = 1'b1;
                stallreq_mem = 1'b1;
            end
            WAIT:  stallreq_mem = 1'b1;
            DRAIN: stallreq_mem = access_valid;
            default: ;
        endcase
    end

    assign load_valid = (state == DONE) && (|load_type_q) && !timed_out;
    assign capture    = (|load_type_q) && dbus.data_ok
                      && ((state == REQ && dbus.addr_ok) || (state == WAIT && !flush));

    // Bus fields are latched once on issue so they stay stable until the slave accepts them
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            dbus.we     <= 1'b0;
            dbus.wstrb  <= 4'b0000;
            dbus.addr   <= 32'h0000_0000;
            dbus.wdata  <= 32'h0000_0000;
            load_type_q <= 5'b00000;
            lane_q      <= 2'b00;
            load_data   <= 32'h0000_0000;
        end else begin
            if (state == IDLE && access_valid) begin
                dbus.we     <= |mem_memtype[7:5];
                dbus.wstrb  <= wstrb_c;
                dbus.addr   <= {mem_addr[31:2], 2'b00};
                dbus.wdata  <= wdata_c;
                load_type_q <= mem_memtype[4:0];
                lane_q      <= mem_addr[1:0];
            end
            if (capture) load_data <= load_ext;
        end
    end

`ifdef DBUS_TIMEOUT_EN
    // req_cnt holds the number of REQ cycles including the current one
    logic [7:0] req_cnt;
    assign time_up = (state == REQ) && (req_cnt == 8'hFF);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            req_cnt   <= 8'h00;
            timed_out <= 1'b0;
        end else begin
            if (state == IDLE && next_state == REQ)     req_cnt <= 8'h01;
            else if (state == REQ && next_state == REQ) req_cnt <= req_cnt + 8'h01;
            else                                        req_cnt <= 8'h00;
            if (state == REQ)
                timed_out <= time_up && !dbus.addr_ok && !flush;
            else if (state == DONE && next_state == IDLE)
                timed_out <= 1'b0;
        end
    end
`else
    assign time_up   = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        mem_exccode_out = EXC_NONE;
        if (mem_exccode_in != EXC_NONE)     mem_exccode_out = mem_exccode_in;
        else if (misaligned)                mem_exccode_out = is_load ? EXC_ADEL : EXC_ADES;
        else if (state == DONE && timed_out) mem_exccode_out = EXC_DBE;
    end
endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed self-checking bench for mem_dbus_ctrl; covers loads, stores, alignment faults,
// flushes, reset mid-transaction and the DBUS_TIMEOUT_EN request timeout.
module tb_mem_dbus_ctrl;
    localparam logic [4:0] EXC_NONE = 5'h1F;
    localparam logic [7:0] MT_LB  = 8'h01;
    localparam logic [7:0] MT_LBU = 8'h02;
    localparam logic [7:0] MT_LH  = 8'h04;
    localparam logic [7:0] MT_LHU = 8'h08;
    localparam logic [7:0] MT_LW  = 8'h10;
    localparam logic [7:0] MT_SB  = 8'h20;
    localparam logic [7:0] MT_SH  = 8'h40;
    localparam logic [7:0] MT_SW  = 8'h80;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        pipe_adv;
    logic [7:0]  mem_memtype;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [4:0]  mem_exccode_in;
    logic        stallreq_mem;
    logic [31:0] load_data;
    logic        load_valid;
    logic [4:0]  mem_exccode_out;

    mem_dbus_ctrl_if dbus();

    mem_dbus_ctrl dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .pipe_adv        (pipe_adv),
        .mem_memtype     (mem_memtype),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_exccode_in  (mem_exccode_in),
        .dbus            (dbus),
        .stallreq_mem    (stallreq_mem),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .mem_exccode_out (mem_exccode_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          stall_cycles;
    int          req_cycles;
    logic        seen_req;
    logic        seen_we;
    logic [3:0]  seen_wstrb;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One access with addr_ok in the first REQ cycle and data_ok in the first WAIT cycle; ends in DONE
    task automatic apply_stimulus(input logic [7:0] mt, input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] rd);
        @(negedge clk);
        mem_memtype = mt; mem_addr = a; mem_din = d; #1;
        @(negedge clk);
        dbus.addr_ok = 1'b1; #1;
        seen_req = dbus.req; seen_we = dbus.we; seen_wstrb = dbus.wstrb;
        seen_addr = dbus.addr; seen_wdata = dbus.wdata;
        @(negedge clk);
        dbus.addr_ok = 1'b0; dbus.data_ok = 1'b1; dbus.rdata = rd; #1;
        @(negedge clk);
        dbus.data_ok = 1'b0; dbus.rdata = 32'h0; #1;
    endtask

    task automatic retire();
        pipe_adv = 1'b1;
        @(negedge clk);
        pipe_adv = 1'b0; mem_memtype = 8'h00; mem_addr = 32'h0; mem_din = 32'h0; #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b1; flush = 1'b0; pipe_adv = 1'b0;
        mem_memtype = 8'h00; mem_addr = 32'h0; mem_din = 32'h0; mem_exccode_in = EXC_NONE;
        dbus.addr_ok = 1'b0; dbus.data_ok = 1'b0; dbus.rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_req", dbus.req, 0);
        check_output("rst_we", dbus.we, 0);
        check_output("rst_wstrb", dbus.wstrb, 0);
        check_output("rst_addr", dbus.addr, 0);
        check_output("rst_wdata", dbus.wdata, 0);
        check_output("rst_stall", stallreq_mem, 0);
        check_output("rst_lvalid", load_valid, 0);
        check_output("rst_ldata", load_data, 0);
        check_output("rst_exc", mem_exccode_out, EXC_NONE);
        @(negedge clk);
        resetn = 1'b0;

        // LW 0x100: addr_ok on the second REQ cycle, data_ok three cycles later
        stall_cycles = 0;
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h100; #1;
        check_output("lw_idle_req", dbus.req, 0);
        stall_cycles += int'(stallreq_mem);
        @(negedge clk); #1;
        check_output("lw_req", dbus.req, 1);
        check_output("lw_addr", dbus.addr, 32'h100);
        check_output("lw_we", dbus.we, 0);
        stall_cycles += int'(stallreq_mem);
        @(negedge clk); dbus.addr_ok = 1'b1; #1;
        stall_cycles += int'(stallreq_mem);
        @(negedge clk); dbus.addr_ok = 1'b0; #1;
        check_output("lw_wait_req", dbus.req, 0);
        stall_cycles += int'(stallreq_mem);
        @(negedge clk); #1;
        stall_cycles += int'(stallreq_mem);
        @(negedge clk); dbus.data_ok = 1'b1; dbus.rdata = 32'hDEADBEEF; #1;
        stall_cycles += int'(stallreq_mem);
        @(negedge clk); dbus.data_ok = 1'b0; dbus.rdata = 32'h0; #1;
        stall_cycles += int'(stallreq_mem);
        check_output("lw_stall_cycles", stall_cycles, 6);
        check_output("lw_lvalid", load_valid, 1);
        check_output("lw_ldata", load_data, 32'hDEADBEEF);
        retire();
        check_output("lw_retired_lvalid", load_valid, 0);

        apply_stimulus(MT_LB, 32'h103, 32'h0, 32'h80FF_FFFF);
        check_output("lb_ldata", load_data, 32'hFFFF_FF80);
        check_output("lb_lvalid", load_valid, 1);
        retire();
        apply_stimulus(MT_LBU, 32'h103, 32'h0, 32'h80FF_FFFF);
        check_output("lbu_ldata", load_data, 32'h0000_0080);
        retire();
        apply_stimulus(MT_LB, 32'h100, 32'h0, 32'h0000_007F);
        check_output("lb0_ldata", load_data, 32'h0000_007F);
        retire();
        apply_stimulus(MT_LH, 32'h102, 32'h0, 32'h8001_1234);
        check_output("lh_ldata", load_data, 32'hFFFF_8001);
        retire();
        apply_stimulus(MT_LHU, 32'h100, 32'h0, 32'h1234_ABCD);
        check_output("lhu_ldata", load_data, 32'h0000_ABCD);
        retire();

        apply_stimulus(MT_SH, 32'h202, 32'h0000_1234, 32'h0);
        check_output("sh_req", seen_req, 1);
        check_output("sh_we", seen_we, 1);
        check_output("sh_wstrb", seen_wstrb, 4'b1100);
        check_output("sh_wdata", seen_wdata, 32'h1234_1234);
        check_output("sh_addr", seen_addr, 32'h200);
        check_output("sh_lvalid", load_valid, 0);
        retire();
        apply_stimulus(MT_SB, 32'h201, 32'h0000_00AB, 32'h0);
        check_output("sb_wstrb", seen_wstrb, 4'b0010);
        check_output("sb_wdata", seen_wdata, 32'hABAB_ABAB);
        retire();
        apply_stimulus(MT_SW, 32'h300, 32'hCAFE_F00D, 32'h0);
        check_output("sw_wstrb", seen_wstrb, 4'b1111);
        check_output("sw_wdata", seen_wdata, 32'hCAFE_F00D);
        check_output("sw_addr", seen_addr, 32'h300);
        retire();

        // Alignment faults and upstream exceptions never reach the bus
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h101; #1;
        check_output("adel_exc", mem_exccode_out, 5'h04);
        check_output("adel_stall", stallreq_mem, 0);
        @(negedge clk); #1;
        check_output("adel_req", dbus.req, 0);
        mem_memtype = MT_SW; mem_addr = 32'h102; #1;
        check_output("ades_exc", mem_exccode_out, 5'h05);
        check_output("ades_stall", stallreq_mem, 0);
        mem_memtype = MT_LW; mem_addr = 32'h100; mem_exccode_in = 5'h0C; #1;
        check_output("upstream_exc", mem_exccode_out, 5'h0C);
        check_output("upstream_stall", stallreq_mem, 0);
        @(negedge clk); #1;
        check_output("upstream_req", dbus.req, 0);
        mem_exccode_in = EXC_NONE; mem_memtype = 8'h00; #1;

        // addr_ok and data_ok together in REQ
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h104; #1;
        @(negedge clk); dbus.addr_ok = 1'b1; dbus.data_ok = 1'b1; dbus.rdata = 32'h1122_3344; #1;
        @(negedge clk); dbus.addr_ok = 1'b0; dbus.data_ok = 1'b0; dbus.rdata = 32'h0; #1;
        check_output("both_lvalid", load_valid, 1);
        check_output("both_ldata", load_data, 32'h1122_3344);
        check_output("both_stall", stallreq_mem, 0);
        retire();

        // Flush in WAIT, then a new LW must wait out the stale response
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h100; #1;
        @(negedge clk); dbus.addr_ok = 1'b1; #1;
        @(negedge clk); dbus.addr_ok = 1'b0; flush = 1'b1; #1;
        @(negedge clk); flush = 1'b0; mem_addr = 32'h400; #1;
        check_output("drain_stall", stallreq_mem, 1);
        check_output("drain_req", dbus.req, 0);
        @(negedge clk); dbus.data_ok = 1'b1; dbus.rdata = 32'hBADB_AD00; #1;
        check_output("drain_dok_req", dbus.req, 0);
        @(negedge clk); dbus.data_ok = 1'b0; dbus.rdata = 32'h0; #1;
        check_output("drain_idle_req", dbus.req, 0);
        check_output("drain_discard", load_data, 32'h1122_3344);
        check_output("drain_lvalid", load_valid, 0);
        @(negedge clk); dbus.addr_ok = 1'b1; #1;
        check_output("drain_new_req", dbus.req, 1);
        check_output("drain_new_addr", dbus.addr, 32'h400);
        @(negedge clk); dbus.addr_ok = 1'b0; dbus.data_ok = 1'b1; dbus.rdata = 32'h5566_7788; #1;
        @(negedge clk); dbus.data_ok = 1'b0; dbus.rdata = 32'h0; #1;
        check_output("drain_new_ldata", load_data, 32'h5566_7788);
        check_output("drain_new_lvalid", load_valid, 1);
        retire();

        // Flush while REQ is still waiting for addr_ok
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h500; #1;
        @(negedge clk); flush = 1'b1; #1;
        check_output("flushreq_req", dbus.req, 1);
        @(negedge clk); flush = 1'b0; mem_memtype = 8'h00; #1;
        check_output("flushreq_idle_req", dbus.req, 0);
        check_output("flushreq_stall", stallreq_mem, 0);

        // Reset during WAIT abandons the transaction
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h700; #1;
        @(negedge clk); dbus.addr_ok = 1'b1; #1;
        @(negedge clk); dbus.addr_ok = 1'b0; resetn = 1'b1; mem_memtype = 8'h00; #1;
        check_output("midrst_stall", stallreq_mem, 0);
        check_output("midrst_addr", dbus.addr, 0);
        check_output("midrst_ldata", load_data, 0);
        @(negedge clk); resetn = 1'b0; #1;
        apply_stimulus(MT_LW, 32'h704, 32'h0, 32'h0BAD_F00D);
        check_output("postrst_req", seen_req, 1);
        check_output("postrst_ldata", load_data, 32'h0BAD_F00D);
        retire();

`ifdef DBUS_TIMEOUT_EN
        // addr_ok never arrives: the request must be withdrawn with a bus error
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h600; #1;
        req_cycles = 0;
        @(negedge clk); #1;
        while (dbus.req && req_cycles < 400) begin
            req_cycles++;
            @(negedge clk); #1;
        end
        check_output("tmo_req_cycles", req_cycles, 255);
        check_output("tmo_exc", mem_exccode_out, 5'h07);
        check_output("tmo_lvalid", load_valid, 0);
        check_output("tmo_stall", stallreq_mem, 0);
        retire();
        check_output("tmo_exc_cleared", mem_exccode_out, EXC_NONE);
`else
        // Without the timeout REQ holds indefinitely
        @(negedge clk); mem_memtype = MT_LW; mem_addr = 32'h600; #1;
        req_cycles = 0;
        repeat (300) begin
            @(negedge clk); #1;
            req_cycles += int'(dbus.req);
        end
        check_output("notmo_req_cycles", req_cycles, 300);
        check_output("notmo_exc", mem_exccode_out, EXC_NONE);
        dbus.addr_ok = 1'b1;
        @(negedge clk); dbus.addr_ok = 1'b0; dbus.data_ok = 1'b1; dbus.rdata = 32'h0000_0600; #1;
        @(negedge clk); dbus.data_ok = 1'b0; #1;
        check_output("notmo_ldata", load_data, 32'h0000_0600);
        retire();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
